// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side packer.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 3;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Mask with the low n bits set; saturates at 32 lanes.
  function automatic logic [31:0] keep_mask(input logic [31:0] n);
    if (n >= 32'd32) begin
      keep_mask = '1;
    end else begin
      keep_mask = (32'd1 << n) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from a first-word-fall-through FIFO and packs PACK of them
// into one wide beat on a valid/ready stream; flush closes a partial beat.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_r_data,
  output logic                       fifo_rd,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int CNT_W = $clog2(PACK);
  localparam logic [CNT_W:0] LAST_LANE = (CNT_W + 1)'(PACK - 1);

  state_t                     state_reg;
  logic [CNT_W:0]             cnt_reg;
  logic [DATA_WIDTH*PACK-1:0] data_reg;
  logic [PACK-1:0]            keep_reg;
  logic                       out_valid_reg;

  logic                       pop;
  logic [CNT_W:0]             fill_next;
  logic [PACK-1:0]            keep_next;
  logic [CNT_W-1:0]           lane_sel;

  always_comb begin
    pop       = !fifo_empty && ((state_reg == S_FILL) || (state_reg == S_HOLD && out_ready));
    // Lane count including a word popped this cycle, used for the flush mask.
    fill_next = cnt_reg + (CNT_W + 1)'(pop);
    keep_next = PACK'(keep_mask(32'(fill_next)));
    lane_sel  = cnt_reg[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_FILL;
      cnt_reg       <= '0;
      data_reg      <= '0;
      keep_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FILL: begin
          if (pop) begin
            data_reg[lane_sel*DATA_WIDTH +: DATA_WIDTH] <= fifo_r_data;
          end
          if ((pop && cnt_reg == LAST_LANE) || (flush && fill_next != '0)) begin
            state_reg     <= S_HOLD;
            out_valid_reg <= 1'b1;
            keep_reg      <= keep_next;
            cnt_reg       <= '0;
          end else begin
            cnt_reg <= fill_next;
          end
        end
        S_HOLD: begin
          // Handshake frees the lanes; a word popped in the same cycle starts the next beat.
          if (out_ready) begin
            state_reg     <= S_FILL;
            out_valid_reg <= 1'b0;
            keep_reg      <= '0;
            data_reg      <= '0;
            if (pop) begin
              data_reg[DATA_WIDTH-1:0] <= fifo_r_data;
              cnt_reg                  <= (CNT_W + 1)'(1);
            end else begin
              cnt_reg <= '0;
            end
          end
        end
        default: state_reg <= S_FILL;
      endcase
    end
  end

  assign fifo_rd   = pop && !reset;
  assign out_data  = data_reg;
  assign out_keep  = keep_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (cnt_reg != '0) || out_valid_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomised and directed bench for fifo_rd_packer against a queue-based beat model.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_rd;
  logic          flush;
  logic [DW*PK-1:0] out_data;
  logic [PK-1:0] out_keep;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // FIFO contents, words gathered into the open beat, and the presented beat.
  int          fifo_q[$];
  int          cur[$];
  bit          hold_v;
  logic [31:0] hold_d;
  logic [3:0]  hold_k;

  // Beats accepted by the downstream side, with the cycle of acceptance.
  logic [31:0] got_d[$];
  logic [3:0]  got_k[$];
  int          got_c[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_cur();
    logic [31:0] d;
    d = 32'd0;
    foreach (cur[i]) d = d | (32'(cur[i]) << (8 * i));
    return d;
  endfunction

  task automatic check_outs();
    chk("out_valid", out_valid, hold_v);
    chk("busy", busy, (cur.size() != 0) || hold_v);
    chk("out_data", out_data, hold_v ? hold_d : pack_cur());
    if (hold_v) chk("out_keep", out_keep, hold_k);
  endtask

  task automatic push(input int w);
    fifo_q.push_back(w);
  endtask

  task automatic clear_got();
    got_d.delete();
    got_k.delete();
    got_c.delete();
  endtask

  // One clock: drive at negedge, check the pop strobe before the edge, advance model, check after.
  task automatic tick(input bit fl, input bit rdy);
    bit          fe;
    bit          ep;
    logic [7:0]  fd;
    fe = (fifo_q.size() == 0);
    fd = fe ? 8'($urandom) : 8'(fifo_q[0]);
    fifo_empty  = fe;
    fifo_r_data = fd;
    flush       = fl;
    out_ready   = rdy;
    #4;
    ep = !fe && (!hold_v || rdy);
    chk("fifo_rd", fifo_rd, ep);
    if (out_valid && rdy) begin
      got_d.push_back(out_data);
      got_k.push_back(out_keep);
      got_c.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (ep) void'(fifo_q.pop_front());
    if (hold_v) begin
      if (rdy) begin
        hold_v = 1'b0;
        cur.delete();
        if (ep) cur.push_back(int'(fd));
      end
    end else begin
      if (ep) cur.push_back(int'(fd));
      if (cur.size() == PK || (fl && cur.size() > 0)) begin
        hold_d = pack_cur();
        hold_k = 4'((1 << cur.size()) - 1);
        hold_v = 1'b1;
        cur.delete();
      end
    end
    #1;
    check_outs();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted away from the clock edge; FIFO contents survive.
  task automatic reset_pulse(input int n);
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() == 0) ? 8'h00 : 8'(fifo_q[0]);
    out_ready   = 1'b1;
    flush       = 1'b0;
    reset       = 1'b1;
    cur.delete();
    hold_v = 1'b0;
    #1;
    check_outs();
    chk("rst_keep", out_keep, 4'h0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_outs();
      chk("rst_fifo_rd_hold", fifo_rd, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    fifo_empty  = 1'b1;
    fifo_r_data = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    hold_v      = 1'b0;
    hold_d      = '0;
    hold_k      = '0;

    reset_pulse(2);

    // Idle after reset with an empty FIFO.
    repeat (10) tick(1'b0, 1'b1);

    // Basic pack.
    clear_got();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (6) tick(1'b0, 1'b1);
    chk("basic_beats", got_d.size(), 1);
    if (got_d.size() >= 1) begin
      chk("basic_data", got_d[0], 32'h44332211);
      chk("basic_keep", got_k[0], 4'b1111);
    end

    // Backpressure, then release with a pop in the handshake cycle.
    clear_got();
    for (int i = 1; i <= 8; i++) push(i);
    repeat (4) tick(1'b0, 1'b0);
    repeat (5) begin
      tick(1'b0, 1'b0);
      chk("bp_hold_data", out_data, 32'h04030201);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_rd_low", fifo_rd, 1'b0);
    end
    repeat (6) tick(1'b0, 1'b1);
    chk("bp_beats", got_d.size(), 2);
    if (got_d.size() >= 2) begin
      chk("bp_data0", got_d[0], 32'h04030201);
      chk("bp_data1", got_d[1], 32'h08070605);
      chk("bp_spacing", got_c[1] - got_c[0], 4);
    end

    // Flush a partial beat, then flush with nothing collected.
    clear_got();
    push(8'hAA); push(8'hBB);
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("flush_beats", got_d.size(), 1);
    if (got_d.size() >= 1) begin
      chk("flush_data", got_d[0], 32'h0000BBAA);
      chk("flush_keep", got_k[0], 4'b0011);
    end
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b0, 1'b1);
    chk("flush_empty_beats", got_d.size(), 1);

    // Flush in the same cycle as the third pop.
    clear_got();
    push(8'hAA); push(8'hBB); push(8'hCC);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("coinc_beats", got_d.size(), 1);
    if (got_d.size() >= 1) begin
      chk("coinc_data", got_d[0], 32'h00CCBBAA);
      chk("coinc_keep", got_k[0], 4'b0111);
    end

    // Reset while a beat is held; the next four words pack normally.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (6) tick(1'b0, 1'b0);
    chk("hold_valid", out_valid, 1'b1);
    chk("hold_data", out_data, 32'h44332211);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    reset_pulse(2);
    clear_got();
    repeat (6) tick(1'b0, 1'b1);
    chk("after_rst_beats", got_d.size(), 1);
    if (got_d.size() >= 1) begin
      chk("after_rst_data", got_d[0], 32'h88776655);
      chk("after_rst_keep", got_k[0], 4'b1111);
    end

    // Randomised traffic with sporadic flushes, backpressure and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 45 && fifo_q.size() < 16) push(int'($urandom_range(0, 255)));
      if ($urandom_range(0, 999) < 3) begin
        reset_pulse(1);
      end else begin
        tick($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 70);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
